local_cycle_controller: RTL and testbench
=========================================

Name: local_cycle_controller

Overview:
- Terminates CPU (68030) bus cycles for the local memory and I/O regions on the k30p board.
- Sits directly downstream of address_decode. It consumes the active-low request_ram, request_rom and request_serial lines, plus the CPU strobes.
- Inserts per-region wait states, then drives the sized DSACK and the device strobes.
- Runs a bus-timeout watchdog that asserts BERR for any cycle nobody terminates, including VME cycles.

Parameters:
- RAM_WAIT, 1, wait-state count for RAM cycles.
- ROM_WAIT, 3, wait-state count for ROM cycles.
- SERIAL_WAIT, 5, wait-state count for serial cycles.
- CNT_WIDTH, 4, width of the wait-state counter.
- TIMEOUT, 255, cycles of cpu_as low with no termination before BERR.
- TIMEOUT_WIDTH, 8, width of the timeout counter.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- n_reset  in  1  reset; synchronous and active-low.
- cpu_as  in  1  CPU address strobe, active-low.
- cpu_ds  in  1  CPU data strobe, active-low.
- cpu_rw  in  1  1 = read, 0 = write.
- request_ram  in  1  active-low, from address_decode.
- request_rom  in  1  active-low, from address_decode.
- request_serial  in  1  active-low, from address_decode.
- ext_dsack  in  2  active-low DSACK returned by the VME bridge; 2'b11 = none.
- cpu_dsack  out  2  active-low local DSACK[1:0]; 2'b11 = released.
- cpu_berr  out  1  active-low bus error.
- ram_oe  out  1  active-low RAM output enable.
- ram_we  out  1  active-low RAM write enable.
- rom_oe  out  1  active-low ROM output enable.
- serial_cs  out  1  active-low serial chip select.

Behaviour:
- Reset:
  - n_reset low at a clock edge forces state IDLE, both counters to 0 and the latched region to none.
  - On that same edge: cpu_dsack=2'b11, cpu_berr=1, all strobes=1.
  - Reset mid-cycle abandons the cycle with no DSACK or BERR.
- State machine: IDLE, WAIT, ACK, EXTERN, BERR. cpu_dsack and cpu_berr are registered.
- IDLE:
  - On an edge with cpu_as=0 and a local request low, latch the region. Priority when several are low: ram > rom > serial.
  - Load wcnt with that region's *_WAIT, then go to WAIT.
  - On an edge with cpu_as=0 and no local request, go to EXTERN.
- WAIT:
  - If cpu_as=1, go to IDLE (aborted cycle, no DSACK).
  - Else if wcnt=0, go to ACK and drive cpu_dsack to the region size on that edge: ram 2'b00 (32-bit), rom 2'b01 (16-bit), serial 2'b10 (8-bit).
  - Else decrement wcnt.
  - Latency: DSACK is asserted on the (N+1)th edge after the IDLE sampling edge, where N = *_WAIT. N=0 gives the edge immediately following.
- ACK:
  - Hold cpu_dsack until an edge samples cpu_as=1.
  - On that edge go to IDLE and set cpu_dsack=2'b11.
- EXTERN:
  - Local cpu_dsack stays 2'b11.
  - If ext_dsack != 2'b11 or cpu_as=1, wait for cpu_as=1, then go to IDLE.
- Timeout:
  - tcnt increments on every edge where cpu_as=0 and the state is not ACK and ext_dsack=2'b11. It saturates and clears on any edge with cpu_as=1.
  - When tcnt reaches TIMEOUT in WAIT or EXTERN, go to BERR and set cpu_berr=0.
  - If ext_dsack asserts on the same edge that tcnt reaches TIMEOUT, termination wins and there is no BERR.
- BERR: hold cpu_berr=0 until cpu_as is sampled 1; go to IDLE and set cpu_berr=1 on that edge.
- Strobes (combinational from the latched region and state, valid only in WAIT or ACK):
  - ram_oe = ~(ram & ~cpu_ds & cpu_rw).
  - ram_we = ~(ram & ~cpu_ds & ~cpu_rw).
  - rom_oe = ~(rom & ~cpu_ds & cpu_rw); ROM writes are terminated normally with no strobe.
  - serial_cs = ~(serial & ~cpu_ds).
  - All strobes are 1 in IDLE, EXTERN and BERR.
- Back-to-back cycles: a new cycle starts only from IDLE, so cpu_as must be sampled high on at least one edge between cycles.
- Width rules: wcnt is CNT_WIDTH bits and must hold the largest *_WAIT. tcnt is TIMEOUT_WIDTH bits and must hold TIMEOUT.

Test Plan:
- RAM read, RAM_WAIT=1, cpu_rw=1, ds low: cpu_dsack=2'b00 two edges after the sampling edge; ram_oe=0 through WAIT/ACK; cpu_dsack=2'b11 on the edge cpu_as is seen high.
- ROM read, ROM_WAIT=3: cpu_dsack=2'b01 on the 4th edge; serial write, SERIAL_WAIT=5: cpu_dsack=2'b10 on the 6th edge with serial_cs=0 and ram_we=1.
- VME cycle (all requests high), ext_dsack=2'b00 after 10 cycles: cpu_dsack stays 2'b11, cpu_berr stays 1, return to IDLE after cpu_as high.
- VME cycle with ext_dsack held 2'b11: cpu_berr=0 once tcnt=255, held until cpu_as high; second case with ext_dsack asserted on the 255th edge gives no BERR.
- Abort: cpu_as rises during ROM WAIT: no DSACK, IDLE next edge; then n_reset low during RAM WAIT: all outputs inactive on that edge.
- Simultaneous request_ram and request_serial low: RAM wins, cpu_dsack=2'b00, serial_cs stays 1.

Source files
------------

// File: rtl/local_cycle_controller.sv
// Local bus-cycle terminator for the 68030 on k30p: inserts per-region wait
// states, returns sized DSACK, drives device strobes, and raises BERR for any
// cycle (local or VME) that nobody terminates in time.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | no cycle in progress; waits for cpu_as low
// S_WAIT   | local region latched, counting down wait states
// S_ACK    | DSACK driven, held until cpu_as returns high
// S_EXTERN | non-local cycle; VME bridge is expected to terminate it
// S_BERR   | watchdog fired, BERR held until cpu_as returns high
module local_cycle_controller #(
    parameter int RAM_WAIT      = 1,
    parameter int ROM_WAIT      = 3,
    parameter int SERIAL_WAIT   = 5,
    parameter int CNT_WIDTH     = 4,
    parameter int TIMEOUT       = 255,
    parameter int TIMEOUT_WIDTH = 8
) (
    input  logic       clock,
    input  logic       n_reset,
    input  logic       cpu_as,
    input  logic       cpu_ds,
    input  logic       cpu_rw,
    input  logic       request_ram,
    input  logic       request_rom,
    input  logic       request_serial,
    input  logic [1:0] ext_dsack,
    output logic [1:0] cpu_dsack,
    output logic       cpu_berr,
    output logic       ram_oe,
    output logic       ram_we,
    output logic       rom_oe,
    output logic       serial_cs
);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACK, S_EXTERN, S_BERR} state_t;
    typedef enum logic [1:0] {REG_NONE, REG_RAM, REG_ROM, REG_SERIAL} region_t;

    localparam logic [CNT_WIDTH-1:0]     RAM_W    = CNT_WIDTH'(RAM_WAIT);
    localparam logic [CNT_WIDTH-1:0]     ROM_W    = CNT_WIDTH'(ROM_WAIT);
    localparam logic [CNT_WIDTH-1:0]     SERIAL_W = CNT_WIDTH'(SERIAL_WAIT);
    localparam logic [TIMEOUT_WIDTH-1:0] TCNT_MAX = TIMEOUT_WIDTH'(TIMEOUT);
    localparam logic [TIMEOUT_WIDTH-1:0] TCNT_PRE = TIMEOUT_WIDTH'(TIMEOUT - 1);

    state_t                   state;
    region_t                  region;
    logic [CNT_WIDTH-1:0]     wcnt;
    logic [TIMEOUT_WIDTH-1:0] tcnt;
    logic                     ext_done;
    logic                     tcnt_inc;
    logic                     timeout_hit;
    logic [1:0]               dsack_size;
    logic                     strobe_en;

    // Watchdog advances only while a cycle is open and unterminated; it
    // fires on the edge where the count would reach TIMEOUT, so an ext_dsack
    // arriving on that edge suppresses both the increment and the BERR.
    assign tcnt_inc    = ~cpu_as && (state != S_ACK) && (ext_dsack == 2'b11);
    assign timeout_hit = tcnt_inc && (tcnt == TCNT_PRE);

    // Port size returned in DSACK for the latched region.
    always_comb begin
        dsack_size = 2'b11;
        case (region)
            REG_RAM:    dsack_size = 2'b00;
            REG_ROM:    dsack_size = 2'b01;
            REG_SERIAL: dsack_size = 2'b10;
            default:    dsack_size = 2'b11;
        endcase
    end

    // Device strobes follow cpu_ds directly while a local cycle is open.
    always_comb begin
        strobe_en = (state == S_WAIT) || (state == S_ACK);
        ram_oe    = ~(strobe_en && (region == REG_RAM)    && ~cpu_ds &&  cpu_rw);
        ram_we    = ~(strobe_en && (region == REG_RAM)    && ~cpu_ds && ~cpu_rw);
        rom_oe    = ~(strobe_en && (region == REG_ROM)    && ~cpu_ds &&  cpu_rw);
        serial_cs = ~(strobe_en && (region == REG_SERIAL) && ~cpu_ds);
    end

    // Bus-timeout counter: clears whenever the address strobe is high.
    always_ff @(posedge clock) begin
        if (!n_reset) begin
            tcnt <= '0;
        end else if (cpu_as) begin
            tcnt <= '0;
        end else if (tcnt_inc && (tcnt != TCNT_MAX)) begin
            tcnt <= tcnt + 1'b1;
        end
    end

    // Cycle FSM with registered DSACK/BERR.
    always_ff @(posedge clock) begin
        if (!n_reset) begin
            state     <= S_IDLE;
            region    <= REG_NONE;
            wcnt      <= '0;
            ext_done  <= 1'b0;
            cpu_dsack <= 2'b11;
            cpu_berr  <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!cpu_as) begin
                        if (!request_ram) begin
                            region <= REG_RAM;
                            wcnt   <= RAM_W;
                            state  <= S_WAIT;
                        end else if (!request_rom) begin
                            region <= REG_ROM;
                            wcnt   <= ROM_W;
                            state  <= S_WAIT;
                        end else if (!request_serial) begin
                            region <= REG_SERIAL;
                            wcnt   <= SERIAL_W;
                            state  <= S_WAIT;
                        end else begin
                            region   <= REG_NONE;
                            ext_done <= 1'b0;
                            state    <= S_EXTERN;
                        end
                    end
                end
                S_WAIT: begin
                    if (cpu_as) begin
                        region <= REG_NONE;
                        state  <= S_IDLE;
                    end else if (wcnt == '0) begin
                        cpu_dsack <= dsack_size;
                        state     <= S_ACK;
                    end else if (timeout_hit) begin
                        region   <= REG_NONE;
                        cpu_berr <= 1'b0;
                        state    <= S_BERR;
                    end else begin
                        wcnt <= wcnt - 1'b1;
                    end
                end
                S_ACK: begin
                    if (cpu_as) begin
                        cpu_dsack <= 2'b11;
                        region    <= REG_NONE;
                        state     <= S_IDLE;
                    end
                end
                S_EXTERN: begin
                    if (cpu_as) begin
                        state <= S_IDLE;
                    end else if (ext_dsack != 2'b11) begin
                        ext_done <= 1'b1;
                    end else if (timeout_hit && !ext_done) begin
                        cpu_berr <= 1'b0;
                        state    <= S_BERR;
                    end
                end
                S_BERR: begin
                    if (cpu_as) begin
                        cpu_berr <= 1'b1;
                        state    <= S_IDLE;
                    end
                end
                default: begin
                    region    <= REG_NONE;
                    cpu_dsack <= 2'b11;
                    cpu_berr  <= 1'b1;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_local_cycle_controller.sv
// Directed bench for local_cycle_controller: local reads/writes per region,
// VME termination, watchdog BERR, abort and reset mid-cycle.
module tb_local_cycle_controller;

    logic       clock;
    logic       n_reset;
    logic       cpu_as;
    logic       cpu_ds;
    logic       cpu_rw;
    logic       request_ram;
    logic       request_rom;
    logic       request_serial;
    logic [1:0] ext_dsack;
    logic [1:0] cpu_dsack;
    logic       cpu_berr;
    logic       ram_oe;
    logic       ram_we;
    logic       rom_oe;
    logic       serial_cs;

    int n_checks = 0;
    int n_errors = 0;

    local_cycle_controller dut (
        .clock          (clock),
        .n_reset        (n_reset),
        .cpu_as         (cpu_as),
        .cpu_ds         (cpu_ds),
        .cpu_rw         (cpu_rw),
        .request_ram    (request_ram),
        .request_rom    (request_rom),
        .request_serial (request_serial),
        .ext_dsack      (ext_dsack),
        .cpu_dsack      (cpu_dsack),
        .cpu_berr       (cpu_berr),
        .ram_oe         (ram_oe),
        .ram_we         (ram_we),
        .rom_oe         (rom_oe),
        .serial_cs      (serial_cs)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One rising edge, then settle #1 so registered outputs are stable.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [7:0] strobes();
        return {4'b0, ram_oe, ram_we, rom_oe, serial_cs};
    endfunction

    task automatic idle_bus();
        cpu_as = 1'b1; cpu_ds = 1'b1; cpu_rw = 1'b1;
        request_ram = 1'b1; request_rom = 1'b1; request_serial = 1'b1;
        ext_dsack = 2'b11;
    endtask

    // Full local cycle: reqs = {ram,rom,serial} active-low, n = wait states.
    // exp_strb = {ram_oe,ram_we,rom_oe,serial_cs} during the cycle.
    task automatic local_cycle(input string tag, input logic [2:0] reqs, input logic rw,
                               input int n, input logic [1:0] size, input logic [3:0] exp_strb);
        cpu_as = 1'b0; cpu_ds = 1'b0; cpu_rw = rw;
        {request_ram, request_rom, request_serial} = reqs;
        for (int i = 0; i <= n; i++) begin
            step();
            check({tag, "_wait_dsack"}, {6'b0, cpu_dsack}, 8'h03);
        end
        check({tag, "_wait_strb"}, strobes(), {4'b0, exp_strb});
        step();
        check({tag, "_dsack"}, {6'b0, cpu_dsack}, {6'b0, size});
        check({tag, "_ack_strb"}, strobes(), {4'b0, exp_strb});
        check({tag, "_berr"}, {7'b0, cpu_berr}, 8'h01);
        step();
        check({tag, "_hold"}, {6'b0, cpu_dsack}, {6'b0, size});
        idle_bus();
        step();
        check({tag, "_release"}, {6'b0, cpu_dsack}, 8'h03);
        check({tag, "_idle_strb"}, strobes(), 8'h0f);
    endtask

    initial begin
        idle_bus();
        n_reset = 1'b0;
        step();
        step();
        check("rst_dsack", {6'b0, cpu_dsack}, 8'h03);
        check("rst_berr", {7'b0, cpu_berr}, 8'h01);
        check("rst_strb", strobes(), 8'h0f);
        n_reset = 1'b1;
        step();

        local_cycle("ram_rd",   3'b011, 1'b1, 1, 2'b00, 4'b0111);
        local_cycle("ram_wr",   3'b011, 1'b0, 1, 2'b00, 4'b1011);
        local_cycle("rom_rd",   3'b101, 1'b1, 3, 2'b01, 4'b1101);
        local_cycle("rom_wr",   3'b101, 1'b0, 3, 2'b01, 4'b1111);
        local_cycle("ser_wr",   3'b110, 1'b0, 5, 2'b10, 4'b1110);
        local_cycle("ram_vs_ser", 3'b010, 1'b1, 1, 2'b00, 4'b0111);

        // VME cycle terminated by the bridge after 10 cycles.
        cpu_as = 1'b0; cpu_ds = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("vme_dsack", {6'b0, cpu_dsack}, 8'h03);
        check("vme_strb", strobes(), 8'h0f);
        ext_dsack = 2'b00;
        for (int i = 0; i < 300; i++) step();
        check("vme_term_dsack", {6'b0, cpu_dsack}, 8'h03);
        check("vme_term_berr", {7'b0, cpu_berr}, 8'h01);
        idle_bus();
        step();
        check("vme_done_berr", {7'b0, cpu_berr}, 8'h01);

        // Unterminated VME cycle: BERR on the 255th edge.
        cpu_as = 1'b0; cpu_ds = 1'b0;
        for (int i = 0; i < 254; i++) step();
        check("to_pre_berr", {7'b0, cpu_berr}, 8'h01);
        step();
        check("to_berr", {7'b0, cpu_berr}, 8'h00);
        check("to_dsack", {6'b0, cpu_dsack}, 8'h03);
        step();
        step();
        check("to_berr_hold", {7'b0, cpu_berr}, 8'h00);
        idle_bus();
        step();
        check("to_berr_release", {7'b0, cpu_berr}, 8'h01);

        // ext_dsack arrives on exactly the 255th edge: no BERR.
        cpu_as = 1'b0; cpu_ds = 1'b0;
        for (int i = 0; i < 254; i++) step();
        ext_dsack = 2'b01;
        step();
        check("race_berr", {7'b0, cpu_berr}, 8'h01);
        step();
        step();
        check("race_berr_later", {7'b0, cpu_berr}, 8'h01);
        idle_bus();
        step();
        check("race_done_berr", {7'b0, cpu_berr}, 8'h01);

        // Abort during ROM WAIT.
        cpu_as = 1'b0; cpu_ds = 1'b0; cpu_rw = 1'b1; request_rom = 1'b0;
        step();
        step();
        check("abort_strb_wait", strobes(), 8'h0d);
        idle_bus();
        step();
        check("abort_dsack", {6'b0, cpu_dsack}, 8'h03);
        check("abort_strb", strobes(), 8'h0f);
        for (int i = 0; i < 4; i++) step();
        check("abort_dsack_later", {6'b0, cpu_dsack}, 8'h03);

        // Reset during RAM WAIT.
        cpu_as = 1'b0; cpu_ds = 1'b0; cpu_rw = 1'b1; request_ram = 1'b0;
        step();
        check("rstmid_strb_wait", strobes(), 8'h07);
        n_reset = 1'b0;
        step();
        check("rstmid_dsack", {6'b0, cpu_dsack}, 8'h03);
        check("rstmid_berr", {7'b0, cpu_berr}, 8'h01);
        check("rstmid_strb", strobes(), 8'h0f);
        n_reset = 1'b1;
        idle_bus();
        step();

        // Controller must be usable again after the mid-cycle reset.
        local_cycle("post_rst", 3'b011, 1'b1, 1, 2'b00, 4'b0111);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
